// File: rtl/joy_conditioner.sv
// joy_conditioner
// Conditioning stage behind the serial joystick reader.
// - Debounces the 12 buttons: bits 5:0 of each pad, on ce cycles only.
// - Applies optional autofire to fire1 (bit 4) of each pad.
// - Queues every debounced press/release as an event byte.
//   The queue is a first-word fall-through FIFO with a valid/ready handshake.
//
// Ports
//   clock      : sole clock
//   reset      : synchronous, active-high reset
//   ce         : sampling enable (shared with the reader)
//   joy1_in    : raw pad 1 vector, bits 7:6 ignored
//   joy2_in    : raw pad 2 vector, bits 7:6 ignored
//   autofire   : per-pad autofire enable (bit 0 = pad 1)
//   joy1, joy2 : registered conditioned vectors, bits 7:6 always 0
//   evt_valid  : event FIFO not empty
//   evt_ready  : consumer accepts the head event
//   evt_data   : head event {press, 3'b000, pad, button[2:0]}
module joy_conditioner #(
    parameter int DEBOUNCE     = 4,
    parameter int AUTOFIRE_DIV = 1024,
    parameter int FIFO_DEPTH   = 8
) (
    input  logic       clock,
    input  logic       reset,
    input  logic       ce,
    input  logic [7:0] joy1_in,
    input  logic [7:0] joy2_in,
    input  logic [1:0] autofire,
    output logic [7:0] joy1,
    output logic [7:0] joy2,
    output logic       evt_valid,
    input  logic       evt_ready,
    output logic [7:0] evt_data
);

    localparam int NBTN  = 12;
    localparam int IDX_W = 4;
    localparam int CNT_W = (DEBOUNCE > 1) ? $clog2(DEBOUNCE) : 1;
    localparam int AF_W  = $clog2(AUTOFIRE_DIV);
    localparam int PTR_W = $clog2(FIFO_DEPTH);

    localparam logic [CNT_W-1:0] DEB_LAST = CNT_W'(DEBOUNCE - 1);
    localparam logic [AF_W-1:0]  AF_LAST  = AF_W'(AUTOFIRE_DIV - 1);

    // Event byte for button index idx (0..11): pad 1 covers 0..5, pad 2 covers 6..11.
    function automatic logic [7:0] encode_evt(input logic [IDX_W-1:0] idx, input logic press);
        logic       pad;
        logic [2:0] bit_idx;
        if (idx >= 4'd6) begin
            pad     = 1'b1;
            bit_idx = 3'(idx - 4'd6);
        end else begin
            pad     = 1'b0;
            bit_idx = idx[2:0];
        end
        return {press, 3'b000, pad, bit_idx};
    endfunction

    logic [NBTN-1:0]  raw_s;
    logic [NBTN-1:0]  stable_r;
    logic [NBTN-1:0]  pending_r;
    logic [NBTN-1:0]  toggle_s;
    logic [NBTN-1:0]  clear_s;
    logic [CNT_W-1:0] cnt_r [NBTN];
    logic [IDX_W-1:0] sel_s;
    logic             any_pending_s;

    logic [7:0]       mem_r [FIFO_DEPTH];
    logic [PTR_W:0]   wr_ptr_r;
    logic [PTR_W:0]   rd_ptr_r;
    logic             empty_s;
    logic             full_s;
    logic             push_s;
    logic             pop_s;

    logic [AF_W-1:0]  af_cnt_r;
    logic             phase_r;

    // Bits 7:6 of the raw vectors carry nothing.
    logic             unused_bits_s;
    assign unused_bits_s = &{1'b0, joy1_in[7:6], joy2_in[7:6]};

    assign raw_s = {joy2_in[5:0], joy1_in[5:0]};

    // A button's stable level flips on the DEBOUNCE-th consecutive differing ce tick.
    always_comb begin
        toggle_s = '0;
        for (int n = 0; n < NBTN; n++) begin
            toggle_s[n] = ce & (raw_s[n] ^ stable_r[n]) & (cnt_r[n] == DEB_LAST);
        end
    end

    // Per-button debounce counters and accepted levels.
    always_ff @(posedge clock) begin
        if (reset) begin
            stable_r <= '0;
            for (int n = 0; n < NBTN; n++) begin
                cnt_r[n] <= '0;
            end
        end else if (ce) begin
            for (int n = 0; n < NBTN; n++) begin
                if (raw_s[n] == stable_r[n]) begin
                    cnt_r[n] <= '0;
                end else if (cnt_r[n] == DEB_LAST) begin
                    stable_r[n] <= raw_s[n];
                    cnt_r[n]    <= '0;
                end else begin
                    cnt_r[n] <= cnt_r[n] + CNT_W'(1);
                end
            end
        end
    end

    // Lowest-index pending button is the next one to be queued.
    always_comb begin
        sel_s = '0;
        for (int n = NBTN - 1; n >= 0; n--) begin
            if (pending_r[n]) begin
                sel_s = IDX_W'(n);
            end else begin
                sel_s = sel_s;
            end
        end
    end

    assign any_pending_s = |pending_r;
    assign empty_s       = (wr_ptr_r == rd_ptr_r);
    assign full_s        = (wr_ptr_r[PTR_W] != rd_ptr_r[PTR_W]) &&
                           (wr_ptr_r[PTR_W-1:0] == rd_ptr_r[PTR_W-1:0]);
    // full is taken before any same-cycle pop, so a full FIFO never accepts a push
    assign push_s        = any_pending_s & ~full_s;
    assign pop_s         = ~empty_s & evt_ready;

    // One-hot mask of the pending bit consumed by this cycle's push.
    always_comb begin
        clear_s = '0;
        if (push_s) begin
            clear_s = {{(NBTN-1){1'b0}}, 1'b1} << sel_s;
        end else begin
            clear_s = '0;
        end
    end

    // Pending flags: clear on push, then flip on toggle, so a same-cycle toggle leaves the bit set
    // and a second toggle before draining cancels the first.
    always_ff @(posedge clock) begin
        if (reset) begin
            pending_r <= '0;
        end else begin
            pending_r <= (pending_r & ~clear_s) ^ toggle_s;
        end
    end

    // FIFO read/write pointers, with one extra wrap bit to tell full from empty.
    always_ff @(posedge clock) begin
        if (reset) begin
            wr_ptr_r <= '0;
            rd_ptr_r <= '0;
        end else begin
            if (push_s) begin
                wr_ptr_r <= wr_ptr_r + (PTR_W+1)'(1);
            end
            if (pop_s) begin
                rd_ptr_r <= rd_ptr_r + (PTR_W+1)'(1);
            end
        end
    end

    // FIFO storage; events carry the debounced level, not the autofire-modulated one.
    always_ff @(posedge clock) begin
        if (push_s) begin
            mem_r[wr_ptr_r[PTR_W-1:0]] <= encode_evt(sel_s, stable_r[sel_s]);
        end
    end

    assign evt_valid = ~empty_s;

    // First-word fall-through head; reads as zero while the FIFO is empty.
    always_comb begin
        evt_data = 8'h00;
        if (empty_s) begin
            evt_data = 8'h00;
        end else begin
            evt_data = mem_r[rd_ptr_r[PTR_W-1:0]];
        end
    end

    // Autofire phase flips every AUTOFIRE_DIV ce ticks; it comes out of reset high.
    always_ff @(posedge clock) begin
        if (reset) begin
            af_cnt_r <= '0;
            phase_r  <= 1'b1;
        end else if (ce) begin
            if (af_cnt_r == AF_LAST) begin
                af_cnt_r <= '0;
                phase_r  <= ~phase_r;
            end else begin
                af_cnt_r <= af_cnt_r + AF_W'(1);
            end
        end
    end

    // Registered conditioned outputs; only fire1 is gated by the autofire phase.
    always_ff @(posedge clock) begin
        if (reset) begin
            joy1 <= 8'h00;
            joy2 <= 8'h00;
        end else begin
            joy1 <= {2'b00, stable_r[5], stable_r[4] & (autofire[0] ? phase_r : 1'b1), stable_r[3:0]};
            joy2 <= {2'b00, stable_r[11], stable_r[10] & (autofire[1] ? phase_r : 1'b1), stable_r[9:6]};
        end
    end

endmodule

// File: doc/joy_conditioner.md
# joy_conditioner

Downstream conditioning stage for the serial joystick reader. Takes the two raw 8-bit pad vectors (bit 0 up, 1 down, 2 left, 3 right, 4 fire1, 5 fire2, bits 7:6 unused, 1 = pressed) and debounces each button. It applies optional autofire to fire1 and outputs cleaned vectors to the machine. Every debounced press/release is also queued as an event byte in a small FIFO with a valid/ready handshake, for the OSD/keyboard-mapping logic.

## Interface
- DEBOUNCE, 4: consecutive ce ticks a raw level must differ from the debounced level before it is accepted (≥1)
- AUTOFIRE_DIV, 1024: ce ticks per autofire half-period (≥2)
- FIFO_DEPTH, 8: event FIFO entries (power of 2, ≥2)

- clock  in  1  system clock; sole clock
- reset  in  1  synchronous, active-high reset
- ce  in  1  sampling enable (same ce that drives the reader)
- joy1_in  in  8  raw pad 1 vector
- joy2_in  in  8  raw pad 2 vector
- autofire  in  2  per-pad autofire enable (bit 0 pad 1, bit 1 pad 2)
- joy1  out  8  conditioned pad 1 vector, bits 7:6 always 0
- joy2  out  8  conditioned pad 2 vector, bits 7:6 always 0
- evt_valid  out  1  FIFO not empty
- evt_ready  in  1  consumer accepts head event
- evt_data  out  8  head event: [7] 1 = press, 0 = release; [6:4] 0; [3] pad (0 = pad 1); [2:0] button index 0–5

## Operation
- 12 buttons, index n = pad*6 + bit. Input bits 7:6 are ignored.
- Debounce per button, evaluated only on ce cycles: if raw == stable, cnt ← 0; else cnt ← cnt+1. When cnt+1 == DEBOUNCE, stable ← raw and cnt ← 0. DEBOUNCE = 1 accepts a change on its first differing ce.
- On each stable toggle, pending[n] ← ~pending[n]. A second toggle before drain cancels the event, so there is no net change.
- Drain on every clock, independent of ce: if any pending and FIFO not full, push the lowest-index pending button with press = its current stable, and clear that pending bit. When toggle and push hit the same bit in the same cycle, toggle wins: pending ends set.
- FIFO is first-word fall-through. evt_valid = !empty. Pop on evt_valid & evt_ready. Full is evaluated before the same-cycle pop, so a full FIFO does not accept a push even when popped. Pending bits hold until space is available; no events are lost.
- Autofire: counter 0..AUTOFIRE_DIV-1 advances on ce. On wrap, phase toggles. Output bit 4 of pad p = stable_fire1 & (autofire[p] ? phase : 1). All other bits = stable. Events always use the unmodulated stable value.
- Reset: stable, cnt, pending, FIFO pointers cleared; phase ← 1; autofire counter ← 0; joy1 = joy2 = 8'h00, evt_valid = 0, evt_data = 8'h00. Reset mid-debounce or with queued events discards everything.

## Timing
- stable updates on the edge ending the DEBOUNCE-th consecutive differing ce cycle (edge E).
- joy1/joy2 are registered from stable/phase and change at E+1.
- Push at E+1 at the earliest. evt_valid rises at E+1, visible in cycle after E+1; evt_data is valid the same cycle.
- Backlog of k simultaneous toggles drains one per clock, in index order.
- Autofire phase toggles every AUTOFIRE_DIV ce ticks. Full period = 2·AUTOFIRE_DIV ticks.
- No combinational path from inputs to outputs except evt_data/evt_valid from FIFO state.

## Test plan
- Debounce: DEBOUNCE=4, ce every cycle, joy1_in=8'h01 held → joy1=8'h01 exactly 5 clocks after first sample, event 8'h80 available; a 3-cycle glitch of 8'h01 → joy1 stays 8'h00, no event.
- Multi-event ordering: joy1_in=8'h30 and joy2_in=8'h04 change together → events pop as 8'h84, 8'h85, 8'h8A on consecutive cycles with evt_ready=1.
- Backpressure: FIFO_DEPTH=8, evt_ready=0, toggle all 12 buttons → 8 events queued, evt_valid held, 4 pending. Then evt_ready=1 → 12 events total, ordered by index, none lost.
- Cancel: evt_ready=0, FIFO full, button 0 pressed then released (both debounced) → no event for button 0 after draining.
- Autofire: AUTOFIRE_DIV=4, autofire=2'b01, fire1 held on both pads → joy1 bit 4 toggles every 4 ce ticks starting high; joy2 bit 4 steady 1. Only one press event per pad.
- Reset: assert reset with 3 queued events and a half-counted debounce → next cycle evt_valid=0, joy1=joy2=8'h00. Held inputs re-debounce from zero after release.
